// File: rtl/accum_pkg.sv
// Shared types and default sizing for the accum_nbit sample accumulator.
package accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } accum_state_t;

  localparam int DEF_BIT_WIDTH   = 8;
  localparam int DEF_NUM_SAMPLES = 4;

endpackage

// File: rtl/adder_nbit.sv
// Plain N-bit ripple adder; overflow is the carry out of the MSB.
module adder_nbit #(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/accum_nbit.sv
// Accumulates NUM_SAMPLES unsigned samples per result with valid/ready handshakes.
// Define ACCUM_SAT_EN to saturate the accumulator on carry instead of wrapping.
module accum_nbit
  import accum_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam int              CW   = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(NUM_SAMPLES - 1);

  accum_state_t         r_state, w_state_nxt;
  logic [BIT_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  logic [BIT_WIDTH-1:0] w_sum;
  logic [BIT_WIDTH-1:0] w_acc_nxt;
  logic                 w_carry;
  logic                 w_accept;
  logic                 w_consume;

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_add (
    .a        (r_acc),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (w_sum),
    .overflow (w_carry)
  );

`ifdef ACCUM_SAT_EN
  // Once all ones, any nonzero sample carries again, so saturation sticks.
  assign w_acc_nxt = w_carry ? {BIT_WIDTH{1'b1}} : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_accept && (r_count == LAST)) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  // Clear outranks both accept and consume; consume and accept never coincide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear || w_consume) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CW'(1);
      r_ovf   <= r_ovf | w_carry;
    end
  end

endmodule

// File: tb/tb_accum_nbit.sv
// Directed self-checking bench for accum_nbit at BIT_WIDTH=8, NUM_SAMPLES=4.
module tb_accum_nbit;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  accum_nbit #(.BIT_WIDTH(8), .NUM_SAMPLES(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: presents one sample for one rising edge; starts and ends on a negedge.
  task automatic feed(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (acc_out !== 8'd0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", acc_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    feed(8'd10); feed(8'd20); feed(8'd30);
    total++; if (out_valid !== 1'b0 || acc_out !== 8'd60) begin bad++;
      $display("FAIL basic_partial got=%b/%0d exp=0/60", out_valid, acc_out); end
    feed(8'd40);
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++;
      $display("FAIL basic_done got=%b/%b exp=1/0", out_valid, in_ready); end
    total++; if (acc_out !== 8'd100 || overflow !== 1'b0) begin bad++;
      $display("FAIL basic_result got=%0d/%b exp=100/0", acc_out, overflow); end
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 8'd0) begin bad++;
      $display("FAIL basic_after_consume got=%b/%b/%0d exp=1/0/0", in_ready, out_valid, acc_out); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_acc;
`ifdef ACCUM_SAT_EN
    exp_acc = 8'd255;
`else
    exp_acc = 8'd46;
`endif
    feed(8'd200); feed(8'd100);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky_mid got=%b exp=1", overflow); end
    feed(8'd1); feed(8'd1);
    total++; if (out_valid !== 1'b1 || acc_out !== exp_acc || overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_result got=%b/%0d/%b exp=1/%0d/1", out_valid, acc_out, overflow, exp_acc); end
    @(negedge clk);
    total++; if (acc_out !== exp_acc || overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_hold got=%0d/%b exp=%0d/1", acc_out, overflow, exp_acc); end
    consume();
    total++; if (overflow !== 1'b0 || acc_out !== 8'd0) begin bad++;
      $display("FAIL ovf_cleared got=%b/%0d exp=0/0", overflow, acc_out); end
  endtask

  task automatic test_stall();
    feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
    in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (acc_out !== 8'd10 || in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
        $display("FAIL stall_cycle%0d got=%0d/%b/%b exp=10/0/1", i, acc_out, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    consume();
    total++; if (acc_out !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL stall_consume got=%0d/%b exp=0/1", acc_out, in_ready); end
    feed(8'd7); feed(8'd7); feed(8'd7); feed(8'd7);
    total++; if (out_valid !== 1'b1 || acc_out !== 8'd28) begin bad++;
      $display("FAIL stall_next got=%b/%0d exp=1/28", out_valid, acc_out); end
    consume();
  endtask

  task automatic test_clear();
    feed(8'd5); feed(8'd6);
    total++; if (acc_out !== 8'd11) begin bad++; $display("FAIL clear_live got=%0d exp=11", acc_out); end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd9;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    total++; if (acc_out !== 8'd0 || in_ready !== 1'b1 || overflow !== 1'b0) begin bad++;
      $display("FAIL clear_zero got=%0d/%b/%b exp=0/1/0", acc_out, in_ready, overflow); end
    feed(8'd1); feed(8'd2); feed(8'd3);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_count got=%b exp=0", out_valid); end
    feed(8'd4);
    total++; if (out_valid !== 1'b1 || acc_out !== 8'd10) begin bad++;
      $display("FAIL clear_result got=%b/%0d exp=1/10", out_valid, acc_out); end
    // Clear together with consume in DONE
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || acc_out !== 8'd0) begin bad++;
      $display("FAIL clear_done got=%b/%0d exp=0/0", out_valid, acc_out); end
  endtask

  task automatic test_async_reset();
    feed(8'd1); feed(8'd2);
    in_valid = 1'b1; in_data = 8'd3;
    #2 n_rst = 1'b0;
    #1;
    total++; if (acc_out !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++;
      $display("FAIL arst_mid got=%0d/%b/%b exp=0/1/0", acc_out, in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0; n_rst = 1'b1;
    @(negedge clk);
    feed(8'd11); feed(8'd12); feed(8'd13); feed(8'd14);
    total++; if (out_valid !== 1'b1 || acc_out !== 8'd50) begin bad++;
      $display("FAIL arst_resume got=%b/%0d exp=1/50", out_valid, acc_out); end
    #2 n_rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || acc_out !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL arst_done got=%b/%0d/%b exp=0/0/1", out_valid, acc_out, in_ready); end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_result got=%b exp=0", out_valid); end
    feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd40);
    total++; if (out_valid !== 1'b1 || acc_out !== 8'd100) begin bad++;
      $display("FAIL arst_full got=%b/%0d exp=1/100", out_valid, acc_out); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
